// File: rtl/sdram_resp_pkg.sv
// Shared types and constants for the SDRAM page responder.
//   state_t       : responder FSM states
//   RW_WRITE/READ : rw_i command encodings
//   *_WD          : counter widths derived from the default timing values
package sdram_resp_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_ACT,
        ST_WRITE,
        ST_READ,
        ST_PRE,
        ST_REF
    } state_t;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    localparam int unsigned BURST_LEN_DEF   = 256;
    localparam int unsigned INIT_CYCLES_DEF = 100;
    localparam int unsigned REF_PERIOD_DEF  = 1560;

    // Beat index, shared INIT/ACT/PRE/REF counter, refresh interval counter.
    localparam int unsigned BEAT_WD = $clog2(BURST_LEN_DEF);
    localparam int unsigned CNT_WD  = $clog2(INIT_CYCLES_DEF);
    localparam int unsigned REF_WD  = $clog2(REF_PERIOD_DEF);

endpackage

// File: rtl/sdram_page_mem.sv
// Single-port synchronous RAM holding the emulated SDRAM pages.
//   clk_i   : clock
//   rst_ni  : async active-low reset (read register only; array is not cleared)
//   en_i    : access enable
//   we_i    : 1 = write wdata_i, 0 = read into rdata_o
//   addr_i  : word address
//   wdata_i : write word
//   rdata_o : read word, 1-cycle latency, holds between reads
module sdram_page_mem #(
    parameter int unsigned DATA_WD = 16,
    parameter int unsigned DEPTH   = 2048,
    parameter int unsigned AW      = 11
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               en_i,
    input  logic               we_i,
    input  logic [AW-1:0]      addr_i,
    input  logic [DATA_WD-1:0] wdata_i,
    output logic [DATA_WD-1:0] rdata_o
);

    logic [DATA_WD-1:0] mem_q [DEPTH];
    logic [DATA_WD-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i && we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (en_i && !we_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sdram_page_responder.sv
// Responder side of the SDRAM controller user handshake. Each accepted request
// moves one full page burst to/from on-chip RAM with controller-like timing.
//   sys_clk_i, rst_ni : clock, async active-low reset
//   rw_i, rw_ena_i    : command (0 write / 1 read) and request strobe
//   addr_i            : page address, low bits select the stored page
//   data_i            : write word, captured the cycle after each strobe
//   data_o            : read word
//   sd_data_valid     : data_o valid this cycle
//   fpga_data_valid   : request for the next write word
//   ready_o           : able to accept a request
//   req_drop_o        : pulse for a request seen while not ready
module sdram_page_responder
    import sdram_resp_pkg::*;
#(
    parameter int unsigned DATA_WD     = 16,
    parameter int unsigned ADDR_WD     = 14,
    parameter int unsigned BURST_LEN   = BURST_LEN_DEF,
    parameter int unsigned MEM_PAGES   = 8,
    parameter int unsigned INIT_CYCLES = INIT_CYCLES_DEF,
    parameter int unsigned ACT_LAT     = 3,
    parameter int unsigned PRE_CYCLES  = 2,
    parameter int unsigned REF_PERIOD  = REF_PERIOD_DEF,
    parameter int unsigned REF_CYCLES  = 8
) (
    input  logic               sys_clk_i,
    input  logic               rst_ni,
    input  logic               rw_i,
    input  logic               rw_ena_i,
    input  logic [ADDR_WD-1:0] addr_i,
    input  logic [DATA_WD-1:0] data_i,
    output logic [DATA_WD-1:0] data_o,
    output logic               sd_data_valid,
    output logic               fpga_data_valid,
    output logic               ready_o,
    output logic               req_drop_o
);

    localparam int unsigned PAGE_WD = $clog2(MEM_PAGES);
    localparam int unsigned MEM_AW  = PAGE_WD + BEAT_WD;

    localparam logic [CNT_WD-1:0]  INIT_LAST   = CNT_WD'(INIT_CYCLES - 1);
    localparam logic [CNT_WD-1:0]  ACT_LAST    = CNT_WD'(ACT_LAT - 1);
    localparam logic [CNT_WD-1:0]  PRE_LAST    = CNT_WD'(PRE_CYCLES - 1);
    localparam logic [CNT_WD-1:0]  REF_LAST    = CNT_WD'(REF_CYCLES - 1);
    localparam logic [BEAT_WD-1:0] BEAT_LAST   = BEAT_WD'(BURST_LEN - 1);
    localparam logic [REF_WD-1:0]  PERIOD_LAST = REF_WD'(REF_PERIOD - 1);

    state_t               state_q, state_d;
    logic [CNT_WD-1:0]    cnt_q, cnt_d;
    logic [BEAT_WD-1:0]   beat_q, beat_d;
    logic [REF_WD-1:0]    ref_cnt_q, ref_cnt_d;
    logic                 ref_due_q, ref_due_d;
    logic                 rw_q, rw_d;
    logic [PAGE_WD-1:0]   page_q, page_d;
    logic                 wr_pend_q, wr_pend_d;
    logic [BEAT_WD-1:0]   wr_beat_q, wr_beat_d;
    logic                 rd_vld_q, rd_vld_d;
    logic                 drop_q, drop_d;

    logic                 mem_en;
    logic                 mem_we;
    logic [MEM_AW-1:0]    mem_addr;

    // Row/bank bits above the stored page index are deliberately ignored.
    logic                 unused_addr_hi;
    assign unused_addr_hi = ^addr_i[ADDR_WD-1:PAGE_WD];

    assign ready_o         = (state_q == ST_IDLE) && !ref_due_q;
    assign fpga_data_valid = (state_q == ST_WRITE);
    assign sd_data_valid   = rd_vld_q;
    assign req_drop_o      = drop_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        beat_d    = beat_q;
        ref_cnt_d = ref_cnt_q;
        ref_due_d = ref_due_q;
        rw_d      = rw_q;
        page_d    = page_q;
        wr_pend_d = 1'b0;
        wr_beat_d = wr_beat_q;
        rd_vld_d  = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;

        unique case (state_q)
            ST_INIT: begin
                if (cnt_q == INIT_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (ref_due_q) begin
                    state_d   = ST_REF;
                    cnt_d     = '0;
                    ref_due_d = 1'b0;
                end else if (rw_ena_i) begin
                    state_d = ST_ACT;
                    cnt_d   = '0;
                    rw_d    = rw_i;
                    page_d  = addr_i[PAGE_WD-1:0];
                end
            end
            ST_ACT: begin
                if (cnt_q == ACT_LAST) begin
                    state_d = (rw_q == RW_READ) ? ST_READ : ST_WRITE;
                    cnt_d   = '0;
                    beat_d  = '0;
                    // Issue beat 0 early so data_o is valid in the first READ cycle.
                    if (rw_q == RW_READ) begin
                        mem_en   = 1'b1;
                        mem_addr = {page_q, {BEAT_WD{1'b0}}};
                        rd_vld_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WRITE: begin
                // Word for this strobe arrives next cycle; remember its beat.
                wr_pend_d = 1'b1;
                wr_beat_d = beat_q;
                if (beat_q == BEAT_LAST) begin
                    state_d = ST_PRE;
                    cnt_d   = '0;
                    beat_d  = '0;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            ST_READ: begin
                if (beat_q == BEAT_LAST) begin
                    state_d = ST_PRE;
                    cnt_d   = '0;
                    beat_d  = '0;
                end else begin
                    beat_d   = beat_q + 1'b1;
                    mem_en   = 1'b1;
                    mem_addr = {page_q, beat_q + 1'b1};
                    rd_vld_d = 1'b1;
                end
            end
            ST_PRE: begin
                if (cnt_q == PRE_LAST) begin
                    cnt_d = '0;
                    if (ref_due_q) begin
                        state_d   = ST_REF;
                        ref_due_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_REF: begin
                if (cnt_q == REF_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase

        // Deferred write capture; never overlaps a read issue.
        if (wr_pend_q) begin
            mem_en   = 1'b1;
            mem_we   = 1'b1;
            mem_addr = {page_q, wr_beat_q};
        end

        // Free-running refresh timer; evaluated after the FSM so a new
        // refresh request is never lost to a same-cycle clear.
        if (state_q != ST_INIT) begin
            if (ref_cnt_q == PERIOD_LAST) begin
                ref_cnt_d = '0;
                ref_due_d = 1'b1;
            end else begin
                ref_cnt_d = ref_cnt_q + 1'b1;
            end
        end

        // Requests held across an accepted burst are not reported as drops.
        drop_d = rw_ena_i && !ready_o &&
                 (state_q == ST_INIT || state_q == ST_IDLE || state_q == ST_REF);
    end

    always_ff @(posedge sys_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_INIT;
            cnt_q     <= '0;
            beat_q    <= '0;
            ref_cnt_q <= '0;
            ref_due_q <= 1'b0;
            rw_q      <= RW_WRITE;
            page_q    <= '0;
            wr_pend_q <= 1'b0;
            wr_beat_q <= '0;
            rd_vld_q  <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            beat_q    <= beat_d;
            ref_cnt_q <= ref_cnt_d;
            ref_due_q <= ref_due_d;
            rw_q      <= rw_d;
            page_q    <= page_d;
            wr_pend_q <= wr_pend_d;
            wr_beat_q <= wr_beat_d;
            rd_vld_q  <= rd_vld_d;
            drop_q    <= drop_d;
        end
    end

    sdram_page_mem #(
        .DATA_WD (DATA_WD),
        .DEPTH   (MEM_PAGES * BURST_LEN),
        .AW      (MEM_AW)
    ) u_mem (
        .clk_i   (sys_clk_i),
        .rst_ni  (rst_ni),
        .en_i    (mem_en),
        .we_i    (mem_we),
        .addr_i  (mem_addr),
        .wdata_i (data_i),
        .rdata_o (data_o)
    );

endmodule
